// File: rtl/load_data_unit.sv
// Load-path data-memory reader: issues one word-aligned bus read per load,
// then aligns and sign/zero-extends the selected byte/half/word for writeback.
module load_data_unit #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [2:0]        io_funct3,
  input  logic [4:0]        io_rd,
  output logic              io_mem_req_valid,
  input  logic              io_mem_req_ready,
  output logic [ADDR_W-1:0] io_mem_addr,
  input  logic              io_mem_resp_valid,
  input  logic [31:0]       io_mem_rdata,
  output logic [31:0]       io_data_mem,
  output logic              io_wb_valid,
  output logic [4:0]        io_wb_rd,
  output logic              io_fault,
  output logic              io_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_FAULT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [4:0]        rd_q, rd_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [31:0]       data_q, data_d;

  logic              reqIllegal;
  logic [7:0]        byteSel;
  logic [15:0]       halfSel;
  logic [31:0]       extracted;

  // Alignment is judged on the incoming request so a bad load never touches the bus
  always_comb begin
    case (io_funct3)
      3'b000, 3'b100: reqIllegal = 1'b0;
      3'b001, 3'b101: reqIllegal = io_addr[0];
      3'b010:         reqIllegal = |io_addr[1:0];
      default:        reqIllegal = 1'b1;
    endcase
  end

  always_comb begin
    byteSel = io_mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    halfSel = addr_q[1] ? io_mem_rdata[31:16] : io_mem_rdata[15:0];
    case (funct3_q)
      3'b000:  extracted = {{24{byteSel[7]}}, byteSel};
      3'b001:  extracted = {{16{halfSel[15]}}, halfSel};
      3'b100:  extracted = {24'b0, byteSel};
      3'b101:  extracted = {16'b0, halfSel};
      default: extracted = io_mem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    case (state_q)
      S_IDLE: begin
        if (io_req_valid) begin
          addr_d   = io_addr;
          funct3_d = io_funct3;
          rd_d     = io_rd;
          state_d  = reqIllegal ? S_FAULT : S_REQ;
        end
      end
      S_REQ: begin
        if (io_mem_req_ready) begin
          cnt_d   = 8'd0;
          state_d = S_WAIT;
        end
      end
      // A response on the last allowed cycle still beats the timeout
      S_WAIT: begin
        if (io_mem_resp_valid) begin
          data_d  = extracted;
          state_d = S_DONE;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      funct3_q <= 3'd0;
      rd_q     <= 5'd0;
      cnt_q    <= 8'd0;
      data_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
    end
  end

  assign io_req_ready     = (state_q == S_IDLE);
  assign io_mem_req_valid = (state_q == S_REQ);
  assign io_mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
  assign io_data_mem      = data_q;
  assign io_wb_valid      = (state_q == S_DONE);
  assign io_wb_rd         = (state_q == S_DONE) ? rd_q : 5'd0;
  assign io_fault         = (state_q == S_FAULT);
  assign io_busy          = (state_q != S_IDLE);

endmodule
